// File: rtl/atpg_pkg.sv
// atpg_pkg: shared FSM state encoding and default MISR constants
package atpg_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FINISH  = 2'd2
    } state_t;
    localparam logic [31:0] DEF_POLY = 32'h0040_0007;
    localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;
endpackage

// File: rtl/atpg_misr_step.sv
// atpg_misr_step: one combinational MISR/LFSR shift with feedback and data injection
module atpg_misr_step #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = 32'h0040_0007
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] nxt
);
    assign nxt = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
endmodule

// File: rtl/atpg_resp_misr.sv
// atpg_resp_misr: compacts a run of response words into a MISR signature and compares it to golden
module atpg_resp_misr
    import atpg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = DEF_POLY,
    parameter logic [WIDTH-1:0] SEED = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      num_vec,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      vec_count
);
    state_t           state, state_nx;
    logic [15:0]      num_q;
    logic [WIDTH-1:0] gold_q, sig_nx;
    logic             pass_q, acc, last;

    atpg_misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .sig(signature),
        .data(resp_data),
        .nxt(sig_nx)
    );

    assign acc        = resp_valid && (state == CAPTURE);
    assign last       = (vec_count + 16'd1) == num_q;
    assign resp_ready = state == CAPTURE;
    assign busy       = state != IDLE;
    assign done       = state == FINISH;
    assign pass       = (state == FINISH) ? (signature == gold_q) : pass_q;

    // state register; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: start only honoured in IDLE, last accepted word ends the capture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (num_vec == 16'd0) ? FINISH : CAPTURE;
            CAPTURE: if (acc && last) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // run parameters, signature, word count and latched verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            signature <= SEED;
            vec_count <= 16'd0;
            pass_q    <= 1'b0;
            num_q     <= 16'd0;
            gold_q    <= '0;
        end else if (state == IDLE && start) begin
            signature <= SEED;
            vec_count <= 16'd0;
            pass_q    <= 1'b0;
            num_q     <= num_vec;
            gold_q    <= golden;
        end else if (acc) begin
            signature <= sig_nx;
            vec_count <= vec_count + 16'd1;
        end else if (state == FINISH) begin
            pass_q    <= signature == gold_q;
        end
    end
endmodule

// File: tb/tb_atpg_resp_misr.sv
// tb_atpg_resp_misr: randomized runs checked every cycle against a behavioural run model
module tb_atpg_resp_misr;
    localparam logic [31:0] P = 32'h0040_0007;
    localparam logic [31:0] S = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vec = 16'd0;
    logic [31:0] golden = 32'd0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic        resp_ready, busy, done, pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int tests = 0;
    int fails = 0;
    int dut_acc = 0;
    int dut_done = 0;
    bit chk_en = 1'b0;

    atpg_resp_misr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .golden(golden),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mstep(logic [31:0] s, logic [31:0] d);
        return (s << 1) ^ (s[31] ? P : 32'h0) ^ d;
    endfunction

    function automatic logic [31:0] fold(logic [31:0] w[$]);
        logic [31:0] s = S;
        foreach (w[i]) s = mstep(s, w[i]);
        return s;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural run model: words left to take, running signature, verdict
    int          m_phase = 0;
    logic [31:0] m_sig = S, m_gold = 0;
    int          m_cnt = 0, m_num = 0;
    bit          m_pass = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_sig = S; m_cnt = 0; m_pass = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_sig = S; m_cnt = 0; m_pass = 0; m_num = num_vec; m_gold = golden;
                m_phase = (num_vec == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (resp_valid) begin
                m_sig = mstep(m_sig, resp_data);
                m_cnt++;
                if (m_cnt == m_num) m_phase = 2;
            end
        end else begin
            m_pass = (m_sig == m_gold);
            m_phase = 0;
        end
    end

    always @(posedge clk) if (rst_n && resp_valid && resp_ready) dut_acc++;

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (done) dut_done++;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("resp_ready", 32'(resp_ready), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("pass", 32'(pass), 32'((m_phase == 2) ? (m_sig == m_gold) : m_pass));
            chk("signature", signature, m_sig);
            chk("vec_count", 32'(vec_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(logic [15:0] n, logic [31:0] g);
        start = 1'b1; num_vec = n; golden = g;
        step();
        start = 1'b0; num_vec = 16'($urandom); golden = $urandom;
    endtask

    task automatic feed(logic [31:0] w, int maxgap);
        int gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (gap) begin
            resp_valid = 1'b0; resp_data = $urandom;
            step();
        end
        resp_valid = 1'b1; resp_data = w;
        step();
        resp_valid = 1'b0; resp_data = $urandom;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            step();
            k++;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wait_done: got timeout expected done pulse");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] g;
        int a0, d0, n;
        step(); step();
        chk_en = 1'b1;
        chk("rst sig", signature, 32'hFFFF_FFFF);
        chk("rst cnt", 32'(vec_count), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst ready", 32'(resp_ready), 0);
        chk("rst pass", 32'(pass), 0);
        rst_n = 1'b1;
        step();

        start_run(1, 32'hFFBF_FFF9);
        feed(32'h0, 0);
        wait_done();
        chk("one done", 32'(done), 1);
        chk("one sig", signature, 32'hFFBF_FFF9);
        chk("one pass", 32'(pass), 1);
        chk("one cnt", 32'(vec_count), 1);
        step();
        chk("one hold pass", 32'(pass), 1);
        chk("one hold sig", signature, 32'hFFBF_FFF9);

        start_run(1, 32'h0);
        feed(32'h0, 0);
        wait_done();
        chk("bad pass", 32'(pass), 0);
        step();

        start_run(0, 32'hFFFF_FFFF);
        chk("zero done", 32'(done), 1);
        chk("zero pass", 32'(pass), 1);
        chk("zero sig", signature, 32'hFFFF_FFFF);
        step();

        w = {};
        for (int i = 0; i < 10; i++) w.push_back($urandom);
        a0 = dut_acc; d0 = dut_done;
        start_run(10, fold(w));
        foreach (w[i]) feed(w[i], 3);
        wait_done();
        chk("ten sig", signature, fold(w));
        chk("ten pass", 32'(pass), 1);
        step(); step();
        chk("ten accepts", 32'(dut_acc - a0), 10);
        chk("ten dones", 32'(dut_done - d0), 1);

        w = {};
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        start_run(4, fold(w));
        feed(w[0], 1);
        start = 1'b1; num_vec = 16'd7; golden = 32'h0;
        step();
        start = 1'b0;
        for (int i = 1; i < 4; i++) feed(w[i], 2);
        wait_done();
        chk("restart cnt", 32'(vec_count), 4);
        chk("restart pass", 32'(pass), 1);
        step();

        d0 = dut_done;
        start_run(10, 32'h1234_5678);
        for (int i = 0; i < 3; i++) feed($urandom, 2);
        rst_n = 1'b0;
        step();
        chk("abort busy", 32'(busy), 0);
        chk("abort sig", signature, 32'hFFFF_FFFF);
        chk("abort cnt", 32'(vec_count), 0);
        rst_n = 1'b1;
        step(); step();
        chk("abort no done", 32'(dut_done - d0), 0);
        w = {};
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        start_run(2, fold(w));
        foreach (w[i]) feed(w[i], 2);
        wait_done();
        chk("after abort pass", 32'(pass), 1);
        step();

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 6);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            g = ($urandom_range(0, 1) == 1) ? fold(w) : $urandom;
            start_run(16'(n), g);
            foreach (w[i]) feed(w[i], 3);
            wait_done();
            chk("rand pass", 32'(pass), 32'(g == fold(w)));
            step();
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
